// File: rtl/if_id_squash_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_squash_reg
// Description : IF/ID pipeline register with squash-to-bubble, stall hold,
//               branch/annul decode, delay-slot tracking and a saturating
//               counter of squashed valid fetches.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_squash_reg #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    CNT_WIDTH  = 8,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'h01000000
) (
  input  logic                  clk,
  input  logic                  system_reset,
  input  logic                  squash_in,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] if_instr,
  input  logic [DATA_WIDTH-1:0] if_pc,
  input  logic [DATA_WIDTH-1:0] if_npc,
  input  logic                  if_valid,
  output logic [DATA_WIDTH-1:0] id_instr,
  output logic [DATA_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_npc,
  output logic                  id_valid,
  output logic                  id_branch_instr,
  output logic                  id_annul_bit,
  output logic                  id_in_delay_slot,
  output logic [CNT_WIDTH-1:0]  squash_count
);

  // SPARC format-2 field positions
  localparam logic [1:0] c_OP_FMT2   = 2'b00;
  localparam logic [2:0] c_OP2_BICC  = 3'b010;
  localparam logic [2:0] c_OP2_FBFCC = 3'b110;

  logic [DATA_WIDTH-1:0] r_instr;
  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_npc;
  logic                  r_valid;
  logic                  r_delay_slot;
  logic [CNT_WIDTH-1:0]  r_squash_cnt;

  logic                  w_is_branch;
  logic                  w_cnt_sat;
  logic                  w_cnt_inc;

  // Branch/annul decode of the instruction currently held in ID
  always_comb begin
    w_is_branch = 1'b0;
    if (r_valid && (r_instr[31:30] == c_OP_FMT2) &&
        ((r_instr[24:22] == c_OP2_BICC) || (r_instr[24:22] == c_OP2_FBFCC))) begin
      w_is_branch = 1'b1;
    end
  end

  // Counter advances only on a squash that discards a real fetch, never wraps
  assign w_cnt_sat = &r_squash_cnt;
  assign w_cnt_inc = squash_in && if_valid && !w_cnt_sat;

  // Pipeline register: squash beats stall beats load
  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      r_instr      <= NOP_WORD;
      r_pc         <= '0;
      r_npc        <= '0;
      r_valid      <= 1'b0;
      r_delay_slot <= 1'b0;
    end else if (squash_in) begin
      r_instr      <= NOP_WORD;
      r_pc         <= if_pc;
      r_npc        <= if_npc;
      r_valid      <= 1'b0;
      r_delay_slot <= 1'b0;
    end else if (!stall) begin
      r_instr      <= if_valid ? if_instr : NOP_WORD;
      r_pc         <= if_pc;
      r_npc        <= if_npc;
      r_valid      <= if_valid;
      // The instruction following a live branch occupies its delay slot
      r_delay_slot <= w_is_branch && if_valid;
    end
  end

  // Saturating debug count of squashed valid fetches
  always_ff @(posedge clk or posedge system_reset) begin
    if (system_reset) begin
      r_squash_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_squash_cnt <= r_squash_cnt + CNT_WIDTH'(1);
    end
  end

  assign id_instr         = r_instr;
  assign id_pc            = r_pc;
  assign id_npc           = r_npc;
  assign id_valid         = r_valid;
  assign id_branch_instr  = w_is_branch;
  assign id_annul_bit     = w_is_branch && r_instr[29];
  assign id_in_delay_slot = r_delay_slot;
  assign squash_count     = r_squash_cnt;

endmodule
`default_nettype wire
